pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the PC, IF/ID, ID/EX and EX/MEM write enables and flushes. Inputs are instruction-fetch completion, data-memory busy, load-use hazard detection and EX-stage redirects. A small FSM clears the pipeline after reset and discards stale fetch responses after a redirect. It also keeps a stall-cycle performance counter.

## Interface
- CNT_W, 32, width of stall/flush performance counters
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- imem_rvalid  in  1  instruction for current PC is available this cycle
- dmem_busy  in  1  MEM-stage data access not yet complete
- id_rs1, id_rs2  in  5  source registers of instruction in IF/ID
- id_uses_rs1, id_uses_rs2  in  1  IF/ID instruction reads rs1/rs2
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_rd  in  5  destination register of ID/EX instruction
- ex_redirect  in  1  taken branch/jump resolved in EX; PC mux selects target
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP (0x00000013) instead of fetched word
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads bubble (all control zero)
- ex_mem_write  out  1  EX/MEM load enable
- stall_cycles  out  CNT_W  cycles with pc_write=0 since reset, saturating
- flush_events  out  CNT_W  count of accepted ex_redirect, saturating

## Operation
- FSM states: BOOT, RUN, DROP. Reset → BOOT.
- BOOT (one cycle): pc_write=0, if_id_flush=1, id_ex_flush=1, if_id_write=1, id_ex_write=1, ex_mem_write=1. Next state is RUN unconditionally.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN/DROP priority, highest first:
  1. dmem_busy: freeze. pc_write, if_id_write, id_ex_write and ex_mem_write are 0. No flushes. In DROP only, imem_rvalid=1 still moves the state to RUN.
  2. ex_redirect: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1, ex_mem_write=1. flush_events+1.
     - In RUN with imem_rvalid=0, go to DROP. In RUN with imem_rvalid=1, stay in RUN.
     - In DROP with imem_rvalid=1, go to RUN. In DROP with imem_rvalid=0, stay in DROP.
  3. load_use: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1. Overrides fetch-wait.
  4. DROP (no redirect): pc_write=0, if_id_write=1, if_id_flush=1, downstream writes=1. imem_rvalid=1 → RUN; the stale word is discarded.
  5. RUN with imem_rvalid=0: pc_write=0, if_id_write=1, if_id_flush=1, downstream writes=1.
  6. Otherwise all write enables 1 and all flushes 0.
- A flush only takes effect together with its stage's write enable. The block never asserts a flush with write=0.
- Counters:
  - stall_cycles increments in every RUN/DROP cycle with pc_write=0. BOOT is not counted.
  - Both counters hold at 2^CNT_W−1 once reached.

## Timing
- All outputs except the counters are combinational from state and current inputs. The state register and counters update on the posedge.
- Reset values: state=BOOT, stall_cycles=0, flush_events=0. The BOOT output pattern applies while resetn=0 and during the first cycle after release.
- Reset asserted mid-operation (any state): the next cycle is BOOT and the counters are cleared.
- Load-use costs exactly one bubble cycle. On the next cycle the load has left ID/EX, so load_use=0.
- Redirect penalty is 2 flushed instructions (IF/ID and ID/EX), plus any DROP cycles.
- Redirect and load_use in the same cycle: the redirect wins, and the load-use stall is not applied.

## Test plan
- Reset: hold resetn=0 for 3 cycles, then release.
  - While resetn=0, and in the first cycle after release: pc_write=0, if_id_flush=1, id_ex_flush=1.
  - Second cycle after release: all write enables are 1 and both counters are 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1.
  - That cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next cycle, with ex_mem_read=0: normal flow. stall_cycles=1.
  - Repeat with ex_rd=0: no stall.
- Fetch wait then redirect: imem_rvalid=0 for 2 cycles, with ex_redirect=1 on the second.
  - Second cycle: pc_write=1 with both flushes, then the FSM enters DROP.
  - Then imem_rvalid=1 arrives: if_id_flush=1 and pc_write=0, and the FSM is in RUN next cycle.
  - flush_events=1.
- dmem_busy=1 for 4 cycles while load_use=1 and ex_redirect=1: every write enable stays 0 and there are no flushes. Then release dmem_busy with ex_redirect=1: the redirect is applied.
- Simultaneous redirect and load-use: id_ex_flush=1, if_id_flush=1, pc_write=1.
- Saturation: with CNT_W=4, hold imem_rvalid=0 for 20 cycles. stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: stage write enables and
// flushes, post-reset pipeline clear, stale-fetch discard, and perf counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             imem_rvalid,
  input  logic             dmem_busy,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {BOOT, RUN, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   load_use;
  logic   redirect_acc;

  // Load in EX whose destination feeds the instruction currently in ID.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= BOOT;
    else         state <= state_nxt;
  end

  // Next state and stage controls; reset forces the BOOT clear pattern.
  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    redirect_acc = 1'b0;

    if (!resetn || state == BOOT) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = RUN;
    end else begin
      // The stale response to the pre-redirect PC is consumed whenever it shows up.
      if (state == DROP && imem_rvalid) state_nxt = RUN;

      if (dmem_busy) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        redirect_acc = 1'b1;
        if (state == RUN && !imem_rvalid) state_nxt = DROP;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (state == DROP || !imem_rvalid) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  // Saturating performance counters; BOOT cycles are not stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (state != BOOT && !pc_write && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_acc && flush_events != CNT_MAX)
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4 so saturation is reachable quickly).
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             resetn;
  logic             imem_rvalid;
  logic             dmem_busy;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int total;
  int bad;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write}
  localparam logic [5:0] P_BOOT   = 6'b011111;
  localparam logic [5:0] P_NORM   = 6'b110101;
  localparam logic [5:0] P_REDIR  = 6'b111111;
  localparam logic [5:0] P_LU     = 6'b000111;
  localparam logic [5:0] P_WAIT   = 6'b011101;
  localparam logic [5:0] P_FREEZE = 6'b000000;

  logic [5:0] ov;
  assign ov = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write};

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .imem_rvalid  (imem_rvalid),
    .dmem_busy    (dmem_busy),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_cnt(input string tag, input int stall_exp, input int flush_exp);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(stall_exp));
    chk({tag, "_flush"}, 32'(flush_events), 32'(flush_exp));
  endtask

  task automatic idle;
    imem_rvalid = 1'b1; dmem_busy = 1'b0; ex_redirect = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    idle();

    // Reset held for three edges, BOOT pattern throughout and one cycle after.
    #1 chk("rst_t0", 32'(ov), 32'(P_BOOT));
    tick(); chk("rst_c1", 32'(ov), 32'(P_BOOT));
    tick(); chk("rst_c2", 32'(ov), 32'(P_BOOT));
    tick(); chk("rst_c3", 32'(ov), 32'(P_BOOT));
    resetn = 1'b1;
    #1 chk("boot_after_release", 32'(ov), 32'(P_BOOT));
    tick(); chk("run_first", 32'(ov), 32'(P_NORM));
    chk_cnt("post_boot", 0, 0);

    // Load-use on rs2: one bubble, counted once.
    set_lu(5'd5);
    #1 chk("load_use", 32'(ov), 32'(P_LU));
    tick(); ex_mem_read = 1'b0;
    #1 chk("after_lu", 32'(ov), 32'(P_NORM));
    chk_cnt("after_lu", 1, 0);
    set_lu(5'd0);
    #1 chk("lu_rd0", 32'(ov), 32'(P_NORM));
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    #1 chk("lu_unused_rs1", 32'(ov), 32'(P_NORM));
    id_uses_rs1 = 1'b1;
    #1 chk("lu_rs1", 32'(ov), 32'(P_LU));
    tick(); idle();
    #1 chk_cnt("lu_done", 2, 0);

    // Fetch wait, then redirect while still waiting -> DROP.
    imem_rvalid = 1'b0;
    #1 chk("fetch_wait", 32'(ov), 32'(P_WAIT));
    tick(); ex_redirect = 1'b1;
    #1 chk("redirect_in_wait", 32'(ov), 32'(P_REDIR));
    tick(); ex_redirect = 1'b0; imem_rvalid = 1'b1;
    #1 chk("drop_stale", 32'(ov), 32'(P_WAIT));
    chk_cnt("in_drop", 3, 1);
    tick();
    #1 chk("back_in_run", 32'(ov), 32'(P_NORM));
    chk_cnt("back_in_run", 4, 1);

    // dmem_busy dominates load-use and redirect for 4 cycles.
    dmem_busy = 1'b1; ex_redirect = 1'b1; set_lu(5'd5);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("freeze_%0d", i), 32'(ov), 32'(P_FREEZE));
      tick();
    end
    chk_cnt("after_freeze", 8, 1);
    dmem_busy = 1'b0;
    #1 chk("redirect_over_lu", 32'(ov), 32'(P_REDIR));
    tick();
    #1 chk("redirect_over_lu2", 32'(ov), 32'(P_REDIR));
    tick(); idle();
    #1 chk("run_after_redir", 32'(ov), 32'(P_NORM));
    chk_cnt("after_redirs", 8, 3);

    // DROP held by dmem_busy; stale response during freeze still exits DROP.
    imem_rvalid = 1'b0; ex_redirect = 1'b1;
    tick(); ex_redirect = 1'b0; dmem_busy = 1'b1;
    #1 chk("drop_busy", 32'(ov), 32'(P_FREEZE));
    tick(); imem_rvalid = 1'b1;
    #1 chk("drop_busy_rvalid", 32'(ov), 32'(P_FREEZE));
    tick(); dmem_busy = 1'b0;
    #1 chk("run_after_busy_drop", 32'(ov), 32'(P_NORM));
    chk_cnt("busy_drop", 10, 4);

    // Redirect in DROP without the stale word stays in DROP.
    imem_rvalid = 1'b0; ex_redirect = 1'b1;
    tick();
    #1 chk("redir_in_drop", 32'(ov), 32'(P_REDIR));
    tick(); ex_redirect = 1'b0; imem_rvalid = 1'b1;
    #1 chk("still_drop", 32'(ov), 32'(P_WAIT));
    tick();
    #1 chk("run_again", 32'(ov), 32'(P_NORM));
    chk_cnt("drop_redir", 11, 6);

    // Mid-operation reset from DROP.
    imem_rvalid = 1'b0; ex_redirect = 1'b1;
    tick(); idle(); resetn = 1'b0;
    #1 chk("midrst_asserted", 32'(ov), 32'(P_BOOT));
    tick(); resetn = 1'b1;
    #1 chk("midrst_boot", 32'(ov), 32'(P_BOOT));
    chk_cnt("midrst", 0, 0);
    tick();
    #1 chk("midrst_run", 32'(ov), 32'(P_NORM));

    // Saturation of stall_cycles at 2^CNT_W-1.
    imem_rvalid = 1'b0;
    repeat (20) tick();
    chk_cnt("sat", 15, 0);
    tick();
    chk_cnt("sat_hold", 15, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
